// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch and
// the load/store stage. Data side has priority, and a starvation guard forces fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        lat_q, lat_d;
  logic              owner_dm_q, owner_dm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              grant_dm, grant_if;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      lat_q       <= '0;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_dm = dm_req && !(if_req && (starve_q == STARVE_LIM));
        grant_if = if_req && !grant_dm;
        if (grant_dm && if_req) begin
          starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end else begin
          starve_d = '0;
        end
        if (grant_dm) begin
          owner_dm_d  = 1'b1;
          we_d        = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          state_d     = ISSUE;
        end else if (grant_if) begin
          owner_dm_d  = 1'b0;
          we_d        = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      // MEM_LAT=1 also passes through WAIT with lat_cnt already 0, which
      // places the capture in the cycle right after ISSUE.
      ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (!we_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
          dm_ack_d = owner_dm_q;
          if_ack_d = !owner_dm_q;
          state_d  = DONE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
